four12_accum_ctrl: RTL
======================

# four12_accum_ctrl

Controller/sequencer for a single four-lane 12-bit SIMD DSP48E2 slice used as a per-lane frame accumulator. It accepts a stream of 48-bit words (four packed 12-bit unsigned lanes) framed by `s_tlast` and drives the slice's OPMODE, clock enables and reset to load, accumulate or hold. It returns each frame's per-lane sum with sticky per-lane overflow flags on a valid/ready output. It sits between a stream source and the shared SIMD-adder DSP instance. The slice's A:B, P and CARRYOUT are wired through this block.

## Interface
- `ABREG`, default 1: A/B register depth configured in the attached slice (0 or 1). Sets controller alignment.
- `clk_i`  in  1: clock. One clock domain.
- `rst_n_i`  in  1: asynchronous, active-low reset.
- `s_tdata_i`  in  48: input word. Lane k is bits [12k+11:12k].
- `s_tvalid_i`  in  1: input valid.
- `s_tlast_i`  in  1: marks the last beat of a frame.
- `s_tready_o`  out  1: input ready.
- `m_tdata_o`  out  48: frame sum, four 12-bit lanes, each modulo 2^12.
- `m_tuser_o`  out  4: sticky per-lane carry-out over the frame.
- `m_tvalid_o`  out  1: result valid.
- `m_tready_i`  in  1: result ready.
- `dsp_ab_o`  out  48: to the slice A:B input. Equals `s_tdata_i`.
- `dsp_ce_ab_o`  out  1: A/B clock enable. Equals `s_tvalid_i & s_tready_o`.
- `dsp_ce_p_o`  out  1: P clock enable. Constant 1.
- `dsp_rst_p_o`  out  1: synchronous P reset to the slice.
- `dsp_opmode_o`  out  9: slice OPMODE.
- `dsp_p_i`  in  48: slice P.
- `dsp_carry_i`  in  4: slice CARRYOUT, registered with P.

## Operation
- Slice configuration required: USE_SIMD FOUR12, ALUMODE sum, CARRYINSEL CARRYIN with CARRYIN=0, OPMODEREG=0, PREG=1, AREG=BREG=ABREG.
- OPMODE codes:
  - LOAD = 9'h003 (X=AB, Y=0, Z=0).
  - ACC = 9'h023 (X=AB, Z=P).
  - HOLD = 9'h020 (X=0, Z=P). HOLD leaves P unchanged.
- Each accepted beat creates a tag {first, last}. `first` is high on the first beat after reset or after a completed frame.
- The tag is delayed ABREG cycles to the ALU stage, then one more cycle to the P stage.
- OPMODE in the ALU cycle:
  - valid tag with first: LOAD.
  - valid tag without first: ACC.
  - no tag (bubble): HOLD.
- Sticky flags at the P stage:
  - first tag: sticky is loaded with `dsp_carry_i`.
  - other valid tags: sticky is ORed with `dsp_carry_i`.
- `m_tdata_o` = `dsp_p_i` (pass-through). `m_tuser_o` = sticky.
- States:
  - INIT: one cycle after reset release. `dsp_rst_p_o`=1, `s_tready_o`=0. Next state is ACCUM.
  - ACCUM: `s_tready_o`=1. Accepting a last beat moves to DRAIN.
  - DRAIN: `s_tready_o`=0. Waits until the last tag reaches the P stage (ABREG+1 cycles), then moves to HOLD.
  - HOLD: `m_tvalid_o`=1. OPMODE is HOLD, so P and sticky are stable. The handshake `m_tvalid_o & m_tready_i` moves to ACCUM.
- A single-beat frame (first and last on the same beat) uses LOAD and yields that beat unchanged.
- Input bubbles (`s_tvalid_i` low) mid-frame do not change the result.
- Reset values:
  - `s_tready_o`=0, `m_tvalid_o`=0, `m_tuser_o`=0.
  - `dsp_opmode_o`=HOLD, `dsp_rst_p_o`=1, `dsp_ce_ab_o`=0.
  - Tags are cleared and the state is INIT.
- Reset mid-frame or mid-HOLD aborts the frame; no output is produced. The partial P is cleared by INIT.

## Timing
- Last beat accepted in cycle t: `m_tvalid_o` rises in cycle t+ABREG+2 and stays high until the handshake.
- OPMODE is registered from the tag pipeline when ABREG=1; it is combinational from the accept when ABREG=0.
- After the handshake in cycle h, `s_tready_o` is 1 in cycle h+1.
- Frame gap is ABREG+2 cycles plus any backpressure. Within a frame, throughput is one beat per cycle.
- The output is not registered; output is valid because P holds.

## Structure
- Package `four12_pkg`:
  - OPMODE constants `OPM_LOAD`, `OPM_ACC`, `OPM_HOLD`.
  - Lane width 12 and lane count 4.
  - State enum {INIT, ACCUM, DRAIN, HOLD}.
- One natural sub-module: `four12_tag_pipe`, a variable-depth tag delay line with valid/first/last fields.
- The DSP slice is instantiated outside this block. The bench pairs the block with a FOUR12 slice or a lane-accurate model.

## Test plan
- Reset: hold `rst_n_i` low → `s_tready_o`=0, `m_tvalid_o`=0, OPMODE 9'h020. First cycle after release: `dsp_rst_p_o`=1. Second cycle: `s_tready_o`=1.
- Three-beat frame, all lanes 0x001, 0x002, 0x003 → `m_tdata_o`=48'h006006006006, `m_tuser_o`=0, `m_tvalid_o` at t_last+ABREG+2.
- Overflow: lane 2 receives 0xFFF then 0x002, other lanes 0x010 each → lane 2 = 0x001, other lanes 0x020, `m_tuser_o`=4'b0100.
- Single-beat frame 48'h123456789ABC → `m_tdata_o`=48'h123456789ABC. Next frame's sticky flags start clear.
- Backpressure: `m_tready_i` low for 5 cycles → `m_tdata_o`/`m_tuser_o` stable, `s_tready_o`=0. After the handshake, the next beat is accepted the following cycle.
- Irregular `s_tvalid_i` mid-frame → result equals the bubble-free sum. Reset asserted mid-frame → all outputs return to reset values, and the following frame sums correctly.

Source files
------------

// File: rtl/four12_pkg.sv
// four12_pkg: shared constants, state encoding and tag type for the FOUR12 accumulator controller.
package four12_pkg;
  localparam int LANE_W = 12;
  localparam int LANES = 4;
  localparam logic [8:0] OPM_LOAD = 9'h003;
  localparam logic [8:0] OPM_ACC = 9'h023;
  localparam logic [8:0] OPM_HOLD = 9'h020;
  typedef enum logic [1:0] {INIT, ACCUM, DRAIN, HOLD} state_t;
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;
  function automatic logic [8:0] tag_opmode(tag_t t);
    return t.valid ? (t.first ? OPM_LOAD : OPM_ACC) : OPM_HOLD;
  endfunction
endpackage

// File: rtl/four12_tag_pipe.sv
// four12_tag_pipe: delays beat tags by DEPTH cycles to the ALU stage and one more to the P stage.
module four12_tag_pipe
  import four12_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t src,
  output tag_t alu,
  output tag_t pst
);
  generate
    if (DEPTH == 0) begin : g_comb
      assign alu = src;
    end else begin : g_dly
      tag_t sr [DEPTH];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= src;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end
      assign alu = sr[DEPTH-1];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pst <= '0;
    else pst <= alu;
  end
endmodule

// File: rtl/four12_accum_ctrl.sv
// four12_accum_ctrl: sequences a FOUR12 SIMD DSP slice to accumulate framed 4x12-bit words per lane.
module four12_accum_ctrl
  import four12_pkg::*;
#(
  parameter int ABREG = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [LANES*LANE_W-1:0]   s_tdata_i,
  input  logic                      s_tvalid_i,
  input  logic                      s_tlast_i,
  output logic                      s_tready_o,
  output logic [LANES*LANE_W-1:0]   m_tdata_o,
  output logic [LANES-1:0]          m_tuser_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic [LANES*LANE_W-1:0]   dsp_ab_o,
  output logic                      dsp_ce_ab_o,
  output logic                      dsp_ce_p_o,
  output logic                      dsp_rst_p_o,
  output logic [8:0]                dsp_opmode_o,
  input  logic [LANES*LANE_W-1:0]   dsp_p_i,
  input  logic [LANES-1:0]          dsp_carry_i
);
  state_t state, state_nx;
  logic first_pend;
  logic [LANES-1:0] sticky;
  logic accept;
  tag_t tag_src, tag_alu, tag_p;
  assign accept = s_tvalid_i & s_tready_o;
  assign tag_src = '{valid: accept, first: first_pend, last: s_tlast_i};
  four12_tag_pipe #(.DEPTH(ABREG)) u_tags (
    .clk(clk_i),
    .rst_n(rst_n_i),
    .src(tag_src),
    .alu(tag_alu),
    .pst(tag_p)
  );
  assign s_tready_o = state == ACCUM;
  assign m_tvalid_o = state == HOLD;
  assign dsp_rst_p_o = state == INIT;
  assign dsp_ab_o = s_tdata_i;
  assign dsp_ce_ab_o = accept;
  assign dsp_ce_p_o = 1'b1;
  assign dsp_opmode_o = tag_opmode(tag_alu);
  assign m_tdata_o = dsp_p_i;
  assign m_tuser_o = sticky;
  always_comb begin
    state_nx = state;
    case (state)
      INIT:  state_nx = ACCUM;
      ACCUM: state_nx = (accept && s_tlast_i) ? DRAIN : ACCUM;
      DRAIN: state_nx = (tag_p.valid && tag_p.last) ? HOLD : DRAIN;
      HOLD:  state_nx = m_tready_i ? ACCUM : HOLD;
      default: state_nx = INIT;
    endcase
  end
  // The next accepted beat opens a new frame whenever the previous accepted beat closed one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= INIT;
      first_pend <= 1'b1;
      sticky <= '0;
    end else begin
      state <= state_nx;
      if (accept) first_pend <= s_tlast_i;
      if (tag_p.valid) sticky <= tag_p.first ? dsp_carry_i : (sticky | dsp_carry_i);
    end
  end
endmodule
